uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_arb_pkg.sv | 27 ++
 rtl/uart_rr_pick.sv | 43 ++++
 rtl/uart_tx_arbiter.sv | 115 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// ============================================================================
//  Module   : uart_arb_pkg
//  Purpose  : Shared state encoding and grant-width helper for uart_tx_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_SEND = 3'd2,
        ST_WAIT = 3'd3,
        ST_HOLD = 3'd4
    } arb_state_t;

    localparam int MIN_N_REQ = 2;
    localparam int MAX_N_REQ = 8;

    function automatic int grant_width(input int n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rr_pick.sv
// ============================================================================
//  Module   : uart_rr_pick
//  Purpose  : Combinational round-robin search starting after last_grant.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int GW    = grant_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [GW-1:0]    last_grant,
    output logic [GW-1:0]    grant,
    output logic             any_req
);

    function automatic logic [GW-1:0] wrap_index(input logic [GW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N_REQ) begin
            sum = sum - N_REQ;
        end
        return sum[GW-1:0];
    endfunction

    // Scan farthest offset first so the nearest requester after last_grant wins.
    always_comb begin
        grant   = last_grant;
        any_req = 1'b0;
        for (int off = N_REQ; off >= 1; off--) begin
            if (req[wrap_index(last_grant, off)]) begin
                grant   = wrap_index(last_grant, off);
                any_req = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
//  Module   : uart_tx_arbiter
//  Purpose  : Round-robin arbiter feeding one UART transmitter from N_REQ
//             byte sources. Define UART_ARB_LOCK_EN to hold the grant until
//             a byte flagged req_last has been sent.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int GW    = grant_width(N_REQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_last,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_done_tick,
    output logic                 busy,
    output logic [GW-1:0]        grant_id
);

    arb_state_t      state;
    arb_state_t      state_next;
    logic [GW-1:0]   last_grant;
    logic [GW-1:0]   grant;
    logic [GW-1:0]   pick;
    logic            any_req;
    logic            load_en;
    logic [GW-1:0]   load_idx;
    logic            hold_wanted;

    uart_rr_pick #(
        .N_REQ (N_REQ),
        .GW    (GW)
    ) u_pick (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (pick),
        .any_req    (any_req)
    );

    // A byte is captured either on a fresh grant in IDLE or on a locked refill in HOLD.
    assign load_en  = ((state == ST_IDLE) && any_req) ||
                      ((state == ST_HOLD) && req_valid[grant]);
    assign load_idx = (state == ST_IDLE) ? pick : grant;

`ifdef UART_ARB_LOCK_EN
    logic last_flag;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_flag <= 1'b0;
        end else if (load_en) begin
            last_flag <= req_last[load_idx];
        end
    end

    assign hold_wanted = ~last_flag;
`else
    logic unused_last;
    assign unused_last = ^req_last;
    assign hold_wanted = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (any_req)           state_next = ST_LOAD;
            ST_LOAD:                        state_next = ST_SEND;
            ST_SEND:                        state_next = ST_WAIT;
            ST_WAIT: if (tx_done_tick)      state_next = hold_wanted ? ST_HOLD : ST_IDLE;
            ST_HOLD: if (req_valid[grant])  state_next = ST_LOAD;
            default:                        state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= GW'(N_REQ - 1);
            grant      <= '0;
            tx_data    <= 8'h00;
        end else begin
            if (load_en) begin
                grant   <= load_idx;
                tx_data <= req_data[{load_idx, 3'b000} +: 8];
            end
            if ((state == ST_WAIT) && tx_done_tick) begin
                last_grant <= grant;
            end
        end
    end

    assign busy      = (state != ST_IDLE);
    assign tx_start  = (state == ST_SEND);
    assign req_ready = (state == ST_LOAD) ? ({{(N_REQ-1){1'b0}}, 1'b1} << grant) : '0;
    assign grant_id  = grant;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
//  Module   : tb_uart_tx_arbiter
//  Purpose  : Directed self-checking bench for uart_tx_arbiter (N_REQ = 4).
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_tx_arbiter;

    localparam int N_REQ = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [N_REQ-1:0]  req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]  req_last;
    logic [N_REQ-1:0]  req_ready;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_done_tick;
    logic              busy;
    logic [1:0]        grant_id;

    logic              model_tick;
    logic              force_tick;
    int                model_cnt;
    int                cyc;
    int                tick_cyc;
    int                start_cnt;
    int                n_assert;
    int                n_fail;
    int                s0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(N_REQ)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_done_tick (tx_done_tick),
        .busy         (busy),
        .grant_id     (grant_id)
    );

    assign tx_done_tick = model_tick | force_tick;

    // UART stand-in: end-of-frame tick about 20 cycles after each start pulse.
    always @(posedge clk) begin
        if (reset) begin
            model_cnt  <= 0;
            model_tick <= 1'b0;
        end else begin
            model_tick <= 1'b0;
            if (tx_start) begin
                model_cnt <= 20;
            end else if (model_cnt == 1) begin
                model_cnt  <= 0;
                model_tick <= 1'b1;
            end else if (model_cnt != 0) begin
                model_cnt <= model_cnt - 1;
            end
        end
    end

    initial begin
        cyc       = 0;
        tick_cyc  = 0;
        start_cnt = 0;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tx_done_tick) tick_cyc <= cyc;
        if (tx_start)     start_cnt <= start_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Waits for the acceptance pulse, checks it and the start pulse one cycle later.
    task automatic xfer(input string tag, input logic [3:0] exp_ready, input logic [1:0] exp_id,
                        input logic [7:0] exp_data, input logic check_gap);
        int waited;
        waited = 0;
        while (req_ready == 4'b0000 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, " ready"}, 32'(req_ready), 32'(exp_ready));
        chk({tag, " grant_id"}, 32'(grant_id), 32'(exp_id));
        @(negedge clk);
        chk({tag, " tx_start"}, 32'(tx_start), 32'd1);
        chk({tag, " tx_data"}, 32'(tx_data), 32'(exp_data));
        if (check_gap) begin
            chk({tag, " gap"}, 32'(cyc - tick_cyc), 32'd3);
        end
    endtask

    task automatic wait_idle(input string tag);
        int waited;
        waited = 0;
        while (busy && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, " idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        n_assert   = 0;
        n_fail     = 0;
        reset      = 1'b1;
        req_valid  = '0;
        req_data   = '0;
        req_last   = '0;
        force_tick = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst ready", 32'(req_ready), 32'd0);
        chk("rst tx_start", 32'(tx_start), 32'd0);
        chk("rst tx_data", 32'(tx_data), 32'h00);
        chk("rst grant_id", 32'(grant_id), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single request: ready at t+1, start at t+2
        req_valid = 4'b0001;
        req_data  = 32'h0000_0058;
        @(negedge clk);
        chk("single ready", 32'(req_ready), 32'b0001);
        chk("single busy", 32'(busy), 32'd1);
        req_valid = 4'b0000;
        @(negedge clk);
        chk("single tx_start", 32'(tx_start), 32'd1);
        chk("single tx_data", 32'(tx_data), 32'h58);
        wait_idle("single");
        chk("single data hold", 32'(tx_data), 32'h58);

        // Round robin, all four valid continuously
        do_reset();
        req_valid = 4'b1111;
        req_data  = 32'h4443_4241;
        xfer("rr1", 4'b0001, 2'd0, 8'h41, 1'b0);
        xfer("rr2", 4'b0010, 2'd1, 8'h42, 1'b1);
        xfer("rr3", 4'b0100, 2'd2, 8'h43, 1'b1);
        xfer("rr4", 4'b1000, 2'd3, 8'h44, 1'b1);
        xfer("rr5", 4'b0001, 2'd0, 8'h41, 1'b1);
        req_valid = 4'b0000;
        wait_idle("rr");

        // Reset in WAIT with requester 1 pending
        req_valid = 4'b0010;
        xfer("pre", 4'b0010, 2'd1, 8'h42, 1'b0);
        repeat (5) @(negedge clk);
        chk("pre wait busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst ready", 32'(req_ready), 32'd0);
        chk("midrst tx_start", 32'(tx_start), 32'd0);
        chk("midrst tx_data", 32'(tx_data), 32'h00);
        chk("midrst grant_id", 32'(grant_id), 32'd0);
        reset = 1'b0;
        s0 = start_cnt;
        xfer("post", 4'b0010, 2'd1, 8'h42, 1'b0);
        req_valid = 4'b0000;
        wait_idle("post");
        chk("post starts", 32'(start_cnt - s0), 32'd1);

        // Spurious ticks in IDLE and in SEND
        s0 = start_cnt;
        force_tick = 1'b1;
        @(negedge clk);
        force_tick = 1'b0;
        chk("spur idle busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("spur idle busy2", 32'(busy), 32'd0);
        chk("spur idle starts", 32'(start_cnt - s0), 32'd0);
        req_valid = 4'b1000;
        xfer("spur", 4'b1000, 2'd3, 8'h44, 1'b0);
        req_valid  = 4'b0000;
        force_tick = 1'b1;
        @(negedge clk);
        force_tick = 1'b0;
        repeat (3) @(negedge clk);
        chk("spur send busy", 32'(busy), 32'd1);
        chk("spur send data", 32'(tx_data), 32'h44);
        wait_idle("spur");
        chk("spur starts", 32'(start_cnt - s0), 32'd1);

        // Message lock: requester 2 sends three bytes while requester 0 waits
        req_valid = 4'b0100;
        req_data  = 32'h44A1_4210;
        req_last  = 4'b0000;
        xfer("msg1", 4'b0100, 2'd2, 8'hA1, 1'b0);
        req_valid = 4'b0101;
        req_data  = 32'h44A2_4210;
`ifdef UART_ARB_LOCK_EN
        xfer("lk2", 4'b0100, 2'd2, 8'hA2, 1'b1);
        req_data  = 32'h44A3_4210;
        req_last  = 4'b0100;
        xfer("lk3", 4'b0100, 2'd2, 8'hA3, 1'b1);
        req_valid = 4'b0001;
        req_last  = 4'b0000;
        xfer("lk4", 4'b0001, 2'd0, 8'h10, 1'b1);
        req_valid = 4'b0000;
`else
        xfer("nl2", 4'b0001, 2'd0, 8'h10, 1'b1);
        xfer("nl3", 4'b0100, 2'd2, 8'hA2, 1'b1);
        req_data  = 32'h44A3_4210;
        req_last  = 4'b0100;
        xfer("nl4", 4'b0001, 2'd0, 8'h10, 1'b1);
        xfer("nl5", 4'b0100, 2'd2, 8'hA3, 1'b1);
        req_valid = 4'b0000;
        req_last  = 4'b0000;
`endif
        wait_idle("msg");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
